// File: rtl/countdown_sequencer_if.sv
// Command/status bundle for countdown_sequencer: control inputs from the
// surrounding logic and the observed count/status outputs.
interface countdown_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             reload;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             paused;
  logic             done;

  modport master (
    output start, load_val, reload, hold, abort,
    input  q, busy, paused, done
  );

  modport slave (
    input  start, load_val, reload, hold, abort,
    output q, busy, paused, done
  );
endinterface

// File: rtl/countdown_sequencer.sv
// Prescaled down counter with start/hold/abort control, optional auto-reload
// and a registered one-cycle done pulse at terminal count.
module countdown_sequencer #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  localparam logic [7:0]       PS_LAST = 8'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [7:0]       presc_reg, presc_next;
  logic [WIDTH-1:0] latch_val_reg, latch_val_next;
  logic             latch_mode_reg, latch_mode_next;
  logic             done_reg, done_next;
  logic             tick;

  assign tick = (presc_reg == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      q_reg          <= '0;
      presc_reg      <= '0;
      latch_val_reg  <= '0;
      latch_mode_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      q_reg          <= q_next;
      presc_reg      <= presc_next;
      latch_val_reg  <= latch_val_next;
      latch_mode_reg <= latch_mode_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    q_next          = q_reg;
    presc_next      = presc_reg;
    latch_val_next  = latch_val_reg;
    latch_mode_next = latch_mode_reg;
    done_next       = 1'b0;

    if (bus.abort) begin
      state_next = S_IDLE;
      q_next     = '0;
      presc_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.load_val == '0) begin
              done_next = 1'b1;
              q_next    = '0;
            end else begin
              q_next          = bus.load_val;
              latch_val_next  = bus.load_val;
              latch_mode_next = bus.reload;
              presc_next      = '0;
              state_next      = S_RUN;
            end
          end
        end
        // The releasing edge of a pause counts like a RUN edge, so a hold of
        // h cycles shifts every later tick by exactly h cycles.
        S_RUN, S_PAUSED: begin
          if (bus.hold) begin
            state_next = S_PAUSED;
          end else begin
            state_next = S_RUN;
            if (tick) begin
              presc_next = '0;
              if (q_reg > ONE) begin
                q_next = q_reg - ONE;
              end else begin
                done_next = 1'b1;
                if (latch_mode_reg) begin
                  q_next = latch_val_reg;
                end else begin
                  q_next     = '0;
                  state_next = S_IDLE;
                end
              end
            end else begin
              presc_next = presc_reg + 8'd1;
            end
          end
        end
        default: begin
          state_next = S_IDLE;
          q_next     = '0;
          presc_next = '0;
        end
      endcase
    end
  end

  assign bus.q      = q_reg;
  assign bus.busy   = (state_reg == S_RUN) || (state_reg == S_PAUSED);
  assign bus.paused = (state_reg == S_PAUSED);
  assign bus.done   = done_reg;

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Synchronous controller that sequences a WIDTH-bit down counter: it loads a start value, decrements once per prescaled tick, and pauses, aborts, or auto-reloads on command. It raises a one-cycle DONE pulse at terminal count. The block replaces free-running ripple down-counting wherever a count must be started, stopped and observed by surrounding control logic. All state is on one clock.

## Interface
- WIDTH, 3: counter width in bits.
- PRESCALE, 1: CLK cycles per decrement tick; legal range 1..255.
- CLK  input  1  clock; all registers update on the rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  begin a count with LOAD_VAL; sampled only in IDLE.
- LOAD_VAL  input  WIDTH  start value; captured on an accepted START.
- RELOAD  input  1  mode, captured on an accepted START: 1 = auto-reload, 0 = one-shot.
- HOLD  input  1  freeze count while high (RUN/PAUSED only).
- ABORT  input  1  cancel the count from any state.
- Q  output  WIDTH  current count value.
- BUSY  output  1  high in RUN and PAUSED.
- PAUSED  output  1  high in PAUSED.
- DONE  output  1  one-cycle pulse at terminal count.

## Operation
- Reset: state IDLE, Q=0, BUSY=0, PAUSED=0, DONE=0, prescaler=0, latched value=0, latched mode=0.
- Input priority on each edge: RST > ABORT > HOLD > tick > START.
- States:
  - IDLE: on START=1, Q<=LOAD_VAL, latch LOAD_VAL and RELOAD, prescaler<=0, go to RUN.
    - If LOAD_VAL=0, do not enter RUN: DONE<=1, Q<=0, stay in IDLE.
  - RUN: the prescaler counts 0..PRESCALE-1. A tick is prescaler==PRESCALE-1; the prescaler wraps to 0 on a tick. On a tick:
    - Q>1: Q<=Q-1.
    - Q==1, one-shot: Q<=0, DONE<=1, go to IDLE.
    - Q==1, auto-reload: Q<=latched value, DONE<=1, stay in RUN.
    - HOLD=1 instead: prescaler and Q keep their values and the state goes to PAUSED. No tick is taken on that edge.
  - PAUSED: everything is frozen. On HOLD=0, go to RUN; the prescaler resumes from its held value.
- ABORT=1 in any state: next state IDLE, Q<=0, prescaler<=0, DONE<=0, so no DONE pulse is produced.
- START outside IDLE is ignored. LOAD_VAL and RELOAD changes after acceptance have no effect on the running count.
- DONE is registered and is high for exactly one cycle per terminal count.
- Q never underflows. In one-shot mode Q stops at 0. In auto-reload mode the period is latched value × PRESCALE cycles.
- Outputs are decoded from registered state: BUSY=(RUN|PAUSED), PAUSED=(state==PAUSED).

## Timing
- START sampled at edge k with value N>0:
  - After edge k: Q=N, BUSY=1.
  - First decrement after edge k+PRESCALE.
  - One-shot terminal count after edge k+N·PRESCALE: Q=0, DONE=1, BUSY=0 in the same cycle.
- A new START is accepted at the edge that ends the DONE cycle. Back-to-back counts therefore lose 0 idle cycles beyond the DONE cycle.
- Auto-reload: DONE pulses every N·PRESCALE cycles and BUSY stays high.
- Pause cost: a HOLD lasting h cycles delays all subsequent ticks by exactly h cycles.
- ABORT or RST asserted at edge j: all outputs are at reset values after edge j. A tick coinciding with ABORT is discarded.
- START with LOAD_VAL=0: DONE=1 and BUSY=0 after the accepting edge; 1-cycle latency.

## Test plan
- Reset then one-shot, WIDTH=3, PRESCALE=1, LOAD_VAL=5: Q sequence is 5,4,3,2,1,0 on consecutive cycles. DONE is high only in the cycle with Q=0. BUSY falls in that same cycle.
- Auto-reload, PRESCALE=2, LOAD_VAL=3: Q holds each value for 2 cycles, 3,3,2,2,1,1,3,3,... DONE pulses every 6 cycles. BUSY stays 1.
- HOLD for 4 cycles while Q=4 in one-shot LOAD_VAL=7: PAUSED=1 for 4 cycles, Q stays 4. DONE arrives exactly 4 cycles later than in an unpaused run.
- ABORT issued on the same edge as the Q=1→0 tick: Q=0, BUSY=0, DONE never asserts. A following START with LOAD_VAL=2 counts normally.
- START with LOAD_VAL=0: single DONE pulse, BUSY stays 0. START pulsed while in RUN: ignored, count unaffected.
- RST asserted mid-count (Q=3, PAUSED or RUN): Q=0, BUSY=0, PAUSED=0, DONE=0 after the edge. START must be re-issued to count.
